// File: rtl/steady_chk_pkg.sv
// Shared types, default widths and a saturating-increment helper for the
// steady-window checker.
package steady_chk_pkg;

   localparam int unsigned DEF_WIDTH = 1;
   localparam int unsigned DEF_CNT_W = 16;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      OPEN   = 2'd1,
      STEADY = 2'd2
   } chk_state_e;

   // Increment v, but hold once the low w bits are all ones (w <= 32).
   function automatic logic [31:0] sat_inc(input logic [31:0] v, input int unsigned w);
      logic [31:0] top;
      top = (w >= 32) ? 32'hFFFF_FFFF : ((32'd1 << w) - 32'd1);
      return (v >= top) ? v : v + 32'd1;
   endfunction

endpackage

// File: rtl/steady_chk_edge.sv
// Previous-tick copies of the sampled clock and the monitored signal,
// producing the falling-edge and change strobes.
module steady_chk_edge
#(
   parameter int unsigned WIDTH = 1
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             smp_clk,
   input  logic [WIDTH-1:0] sig,
   output logic             fall,
   output logic             chg
);

   logic             smp_q;
   logic [WIDTH-1:0] sig_q;

   // Reset preloads smp_q high and sig_q with the live value so the first
   // tick out of reset sees neither a false fall nor a false change.
   always_ff @(posedge clk) begin
      if (rst) begin
         smp_q <= 1'b1;
         sig_q <= sig;
      end else begin
         smp_q <= smp_clk;
         sig_q <= sig;
      end
   end

   assign fall = smp_q & ~smp_clk;
   assign chg  = (sig != sig_q);

endmodule

// File: rtl/steady_window_checker.sv
// Checks that sig stays steady between falling edges of smp_clk.
// Define STEADY_CHK_MAXWIN_EN to build the max_window tracker and port.
module steady_window_checker
   import steady_chk_pkg::*;
#(
   parameter int unsigned WIDTH = DEF_WIDTH,
   parameter int unsigned CNT_W = DEF_CNT_W
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             smp_clk,
   input  logic [WIDTH-1:0] sig,
   input  logic             clr,
   output logic             violation,
   output logic             err_sticky,
   output logic [CNT_W-1:0] viol_count,
   output logic             win_done,
   output logic [CNT_W-1:0] window_len
`ifdef STEADY_CHK_MAXWIN_EN
   ,
   output logic [CNT_W-1:0] max_window
`endif
);

   logic fall;
   logic chg;

   steady_chk_edge #(
      .WIDTH (WIDTH)
   ) u_edge (
      .clk     (clk),
      .rst     (rst),
      .smp_clk (smp_clk),
      .sig     (sig),
      .fall    (fall),
      .chg     (chg)
   );

   chk_state_e       state_q, state_d;
   logic [CNT_W-1:0] len_q, len_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic [CNT_W-1:0] wlen_q, wlen_d;
   logic             sticky_q, sticky_d;
   logic             viol_q, viol_d;
   logic             done_q, done_d;
   logic             close;

   always_comb begin
      state_d  = state_q;
      len_d    = len_q;
      cnt_d    = cnt_q;
      wlen_d   = wlen_q;
      sticky_d = sticky_q;
      viol_d   = (state_q == STEADY) && chg;
      close    = fall && (state_q == STEADY);
      done_d   = close;

      if (fall) begin
         state_d = OPEN;
      end else if (state_q != IDLE) begin
         state_d = STEADY;
      end

      if (close) begin
         wlen_d = len_q;
         len_d  = '0;
      end else if (!fall && state_q == OPEN) begin
         len_d = CNT_W'(1);
      end else if (!fall && state_q == STEADY) begin
         len_d = CNT_W'(sat_inc(32'(len_q), CNT_W));
      end

      // Clear takes priority over a coincident violation.
      if (clr) begin
         cnt_d    = '0;
         sticky_d = 1'b0;
      end else if (viol_d) begin
         cnt_d    = CNT_W'(sat_inc(32'(cnt_q), CNT_W));
         sticky_d = 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q  <= IDLE;
         len_q    <= '0;
         cnt_q    <= '0;
         wlen_q   <= '0;
         sticky_q <= 1'b0;
         viol_q   <= 1'b0;
         done_q   <= 1'b0;
      end else begin
         state_q  <= state_d;
         len_q    <= len_d;
         cnt_q    <= cnt_d;
         wlen_q   <= wlen_d;
         sticky_q <= sticky_d;
         viol_q   <= viol_d;
         done_q   <= done_d;
      end
   end

`ifdef STEADY_CHK_MAXWIN_EN
   logic [CNT_W-1:0] max_q;

   always_ff @(posedge clk) begin
      if (rst || clr) begin
         max_q <= '0;
      end else if (close && (len_q > max_q)) begin
         max_q <= len_q;
      end
   end

   assign max_window = max_q;
`endif

   assign violation  = viol_q;
   assign err_sticky = sticky_q;
   assign viol_count = cnt_q;
   assign win_done   = done_q;
   assign window_len = wlen_q;

endmodule

// File: tb/tb_steady_window_checker.sv
// Directed bench for steady_window_checker; max_window checks follow
// STEADY_CHK_MAXWIN_EN.
module tb_steady_window_checker;

   logic        clk = 1'b0;
   logic        rst = 1'b0;
   logic        smp_clk = 1'b1;
   logic [0:0]  sig = 1'b0;
   logic        clr = 1'b0;
   logic        violation;
   logic        err_sticky;
   logic [15:0] viol_count;
   logic        win_done;
   logic [15:0] window_len;
`ifdef STEADY_CHK_MAXWIN_EN
   logic [15:0] max_window;
`endif

   int vectors = 0;
   int miscompares = 0;

   steady_window_checker dut (
      .clk        (clk),
      .rst        (rst),
      .smp_clk    (smp_clk),
      .sig        (sig),
      .clr        (clr),
      .violation  (violation),
      .err_sticky (err_sticky),
      .viol_count (viol_count),
      .win_done   (win_done),
      .window_len (window_len)
`ifdef STEADY_CHK_MAXWIN_EN
      ,
      .max_window (max_window)
`endif
   );

   always #5 clk = ~clk;

   task automatic step(input logic s_smp, input logic s_sig);
      smp_clk = s_smp;
      sig     = s_sig;
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      clr = 1'b0;
      rst = 1'b1;
      step(1'b1, 1'b0);
      rst = 1'b0;
   endtask

   task automatic test_reset();
      rst = 1'b1;
      step(1'b1, 1'b0);
      step(1'b1, 1'b1);
      rst = 1'b0;
      vectors++; if (violation !== 1'b0) begin miscompares++; $display("FAIL reset_violation got %0h want 0", violation); end
      vectors++; if (err_sticky !== 1'b0) begin miscompares++; $display("FAIL reset_sticky got %0h want 0", err_sticky); end
      vectors++; if (viol_count !== 16'h0) begin miscompares++; $display("FAIL reset_count got %0h want 0", viol_count); end
      vectors++; if (win_done !== 1'b0) begin miscompares++; $display("FAIL reset_win_done got %0h want 0", win_done); end
      vectors++; if (window_len !== 16'h0) begin miscompares++; $display("FAIL reset_window_len got %0h want 0", window_len); end
`ifdef STEADY_CHK_MAXWIN_EN
      vectors++; if (max_window !== 16'h0) begin miscompares++; $display("FAIL reset_max_window got %0h want 0", max_window); end
`endif
   endtask

   // smp_clk period 8, sig changes only on the tick after each fall.
   task automatic test_steady_windows();
      logic s;
      logic exp_done;
      s = 1'b0;
      do_reset();
      for (int i = 0; i < 40; i++) begin
         if (i >= 5 && ((i - 5) % 8) == 0) s = ~s;
         step(((i / 4) % 2) == 0, s);
         exp_done = (i >= 12) && (((i - 4) % 8) == 0);
         vectors++; if (violation !== 1'b0) begin miscompares++; $display("FAIL steady_violation tick %0d got %0h want 0", i, violation); end
         vectors++; if (win_done !== exp_done) begin miscompares++; $display("FAIL steady_win_done tick %0d got %0h want %0h", i, win_done, exp_done); end
         if (exp_done) begin
            vectors++; if (window_len !== 16'd7) begin miscompares++; $display("FAIL steady_window_len tick %0d got %0d want 7", i, window_len); end
         end
      end
      vectors++; if (viol_count !== 16'h0) begin miscompares++; $display("FAIL steady_count got %0h want 0", viol_count); end
   endtask

   task automatic test_violation();
      do_reset();
      step(1'b1, 1'b0);
      step(1'b0, 1'b0);
      step(1'b0, 1'b0);
      vectors++; if (violation !== 1'b0) begin miscompares++; $display("FAIL viol_pre1 got %0h want 0", violation); end
      step(1'b0, 1'b0);
      vectors++; if (violation !== 1'b0) begin miscompares++; $display("FAIL viol_pre2 got %0h want 0", violation); end
      step(1'b0, 1'b1);
      vectors++; if (violation !== 1'b1) begin miscompares++; $display("FAIL viol_pulse got %0h want 1", violation); end
      vectors++; if (viol_count !== 16'd1) begin miscompares++; $display("FAIL viol_count got %0h want 1", viol_count); end
      vectors++; if (err_sticky !== 1'b1) begin miscompares++; $display("FAIL viol_sticky got %0h want 1", err_sticky); end
      for (int i = 0; i < 3; i++) begin
         step(1'b0, 1'b1);
         vectors++; if (violation !== 1'b0) begin miscompares++; $display("FAIL viol_after tick %0d got %0h want 0", i, violation); end
         vectors++; if (err_sticky !== 1'b1) begin miscompares++; $display("FAIL viol_sticky_hold tick %0d got %0h want 1", i, err_sticky); end
         vectors++; if (viol_count !== 16'd1) begin miscompares++; $display("FAIL viol_count_hold tick %0d got %0h want 1", i, viol_count); end
      end
   endtask

   task automatic test_idle_toggle();
      logic s;
      s = 1'b0;
      do_reset();
      for (int i = 0; i < 10; i++) begin
         s = ~s;
         step(1'b1, s);
         vectors++; if (violation !== 1'b0) begin miscompares++; $display("FAIL idle_violation tick %0d got %0h want 0", i, violation); end
      end
      vectors++; if (viol_count !== 16'h0) begin miscompares++; $display("FAIL idle_count got %0h want 0", viol_count); end
      vectors++; if (err_sticky !== 1'b0) begin miscompares++; $display("FAIL idle_sticky got %0h want 0", err_sticky); end
   endtask

   task automatic test_saturate();
      logic s;
      s = 1'b0;
      do_reset();
      step(1'b1, s);
      step(1'b0, s);
      step(1'b0, s);
      for (int i = 0; i < 65534; i++) begin
         s = ~s;
         step(1'b0, s);
      end
      vectors++; if (viol_count !== 16'hFFFE) begin miscompares++; $display("FAIL sat_fffe got %0h want fffe", viol_count); end
      s = ~s;
      step(1'b0, s);
      vectors++; if (viol_count !== 16'hFFFF) begin miscompares++; $display("FAIL sat_ffff got %0h want ffff", viol_count); end
      s = ~s;
      step(1'b0, s);
      vectors++; if (viol_count !== 16'hFFFF) begin miscompares++; $display("FAIL sat_hold got %0h want ffff", viol_count); end
      vectors++; if (violation !== 1'b1) begin miscompares++; $display("FAIL sat_violation got %0h want 1", violation); end
   endtask

   task automatic test_clr_collision();
      do_reset();
      step(1'b1, 1'b0);
      step(1'b0, 1'b0);
      step(1'b0, 1'b0);
      step(1'b0, 1'b1);
      vectors++; if (viol_count !== 16'd1) begin miscompares++; $display("FAIL clr_pre_count got %0h want 1", viol_count); end
      step(1'b0, 1'b1);
      clr = 1'b1;
      step(1'b0, 1'b0);
      clr = 1'b0;
      vectors++; if (viol_count !== 16'd0) begin miscompares++; $display("FAIL clr_count got %0h want 0", viol_count); end
      vectors++; if (err_sticky !== 1'b0) begin miscompares++; $display("FAIL clr_sticky got %0h want 0", err_sticky); end
      step(1'b0, 1'b0);
      vectors++; if (viol_count !== 16'd0) begin miscompares++; $display("FAIL clr_quiet_count got %0h want 0", viol_count); end
      step(1'b0, 1'b1);
      vectors++; if (viol_count !== 16'd1) begin miscompares++; $display("FAIL clr_next_count got %0h want 1", viol_count); end
      vectors++; if (err_sticky !== 1'b1) begin miscompares++; $display("FAIL clr_next_sticky got %0h want 1", err_sticky); end
   endtask

   task automatic test_rst_mid_window();
      logic s;
      s = 1'b0;
      do_reset();
      step(1'b1, s);
      step(1'b0, s);
      step(1'b0, s);
      step(1'b0, s);
      rst = 1'b1;
      s = ~s;
      step(1'b1, s);
      rst = 1'b0;
      vectors++; if (violation !== 1'b0) begin miscompares++; $display("FAIL rst_violation got %0h want 0", violation); end
      vectors++; if (err_sticky !== 1'b0) begin miscompares++; $display("FAIL rst_sticky got %0h want 0", err_sticky); end
      vectors++; if (viol_count !== 16'h0) begin miscompares++; $display("FAIL rst_count got %0h want 0", viol_count); end
      vectors++; if (win_done !== 1'b0) begin miscompares++; $display("FAIL rst_win_done got %0h want 0", win_done); end
      step(1'b1, s);
      vectors++; if (violation !== 1'b0) begin miscompares++; $display("FAIL rst_first_tick got %0h want 0", violation); end
      s = ~s;
      step(1'b1, s);
      vectors++; if (violation !== 1'b0) begin miscompares++; $display("FAIL rst_idle_chg got %0h want 0", violation); end
      s = ~s;
      step(1'b0, s);
      vectors++; if (violation !== 1'b0) begin miscompares++; $display("FAIL rst_fall_chg got %0h want 0", violation); end
      vectors++; if (win_done !== 1'b0) begin miscompares++; $display("FAIL rst_no_close got %0h want 0", win_done); end
      s = ~s;
      step(1'b0, s);
      vectors++; if (violation !== 1'b0) begin miscompares++; $display("FAIL rst_open_chg got %0h want 0", violation); end
      s = ~s;
      step(1'b0, s);
      vectors++; if (violation !== 1'b1) begin miscompares++; $display("FAIL rst_steady_chg got %0h want 1", violation); end
   endtask

   // Falls 6, 10 and 4 ticks apart give windows of 5, 9 and 3 ticks.
   task automatic test_window_lengths();
      int gaps [3];
      int exp_max;
      gaps = '{6, 10, 4};
      exp_max = 0;
      do_reset();
      step(1'b1, 1'b0);
      for (int k = 0; k < 4; k++) begin
         step(1'b0, 1'b0);
         vectors++; if (win_done !== (k != 0)) begin miscompares++; $display("FAIL win_done_close %0d got %0h want %0h", k, win_done, (k != 0)); end
         if (k != 0) begin
            if (gaps[k-1] - 1 > exp_max) exp_max = gaps[k-1] - 1;
            vectors++; if (window_len !== 16'(gaps[k-1] - 1)) begin miscompares++; $display("FAIL win_len %0d got %0d want %0d", k, window_len, gaps[k-1] - 1); end
`ifdef STEADY_CHK_MAXWIN_EN
            vectors++; if (max_window !== 16'(exp_max)) begin miscompares++; $display("FAIL max_window %0d got %0d want %0d", k, max_window, exp_max); end
`endif
         end
         if (k < 3) begin
            for (int j = 1; j < gaps[k]; j++) begin
               step(j == gaps[k] - 1, 1'b0);
               vectors++; if (win_done !== 1'b0) begin miscompares++; $display("FAIL win_done_idle %0d.%0d got %0h want 0", k, j, win_done); end
            end
         end
      end
`ifdef STEADY_CHK_MAXWIN_EN
      vectors++; if (max_window !== 16'd9) begin miscompares++; $display("FAIL max_window_final got %0d want 9", max_window); end
`endif
   endtask

   initial begin
      test_reset();
      test_steady_windows();
      test_violation();
      test_idle_toggle();
      test_clr_collision();
      test_rst_mid_window();
      test_window_lengths();
      test_saturate();
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
